// File: rtl/lsu.sv
// Load/store unit: one bus transaction per instruction,
// aligned/extended result handed to writeback.
module lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rd_i,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_wen,
  output logic [XLEN-1:0] req_addr,
  output logic [63:0]     req_wdata,
  output logic [7:0]      req_wmask,
  input  logic            resp_valid,
  input  logic [63:0]     resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic       ld;
  logic [2:0] f3;
  logic [2:0] off;

  logic        in_off;
  logic        mis;
  logic [63:0] repl;
  logic [7:0]  mbase;
  logic [63:0] sh;
  logic [63:0] ext;

  assign in_ready  = (state == IDLE);
  assign req_valid = (state == REQ);
  assign out_valid = (state == DONE);

  // size comes from funct3[1:0] for both loads and stores
  always_comb begin
    mis   = 1'b0;
    repl  = wdata_i[63:0];
    mbase = 8'hff;
    in_off = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        repl  = {8{wdata_i[7:0]}};
        mbase = 8'h01;
      end
      2'b01: begin
        mis   = addr_i[0];
        repl  = {4{wdata_i[15:0]}};
        mbase = 8'h03;
      end
      2'b10: begin
        mis   = |addr_i[1:0];
        repl  = {2{wdata_i[31:0]}};
        mbase = 8'h0f;
      end
      default: begin
        mis   = |addr_i[2:0];
        mbase = 8'hff;
      end
    endcase
    in_off = is_load_i | is_store_i;
  end

  always_comb begin
    sh  = resp_rdata >> {off, 3'b000};
    ext = sh;
    case (f3)
      3'b000:  ext = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ext = {{32{sh[31]}}, sh[31:0]};
      3'b100:  ext = {56'd0, sh[7:0]};
      3'b101:  ext = {48'd0, sh[15:0]};
      3'b110:  ext = {32'd0, sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ld           <= 1'b0;
      f3           <= 3'd0;
      off          <= 3'd0;
      req_wen      <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= 64'd0;
      req_wmask    <= 8'd0;
      out_data     <= '0;
      out_rd       <= 5'd0;
      out_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ld     <= is_load_i;
            f3     <= funct3_i;
            off    <= addr_i[2:0];
            out_rd <= rd_i;
            if (!in_off) begin
              out_data     <= addr_i;
              out_misalign <= 1'b0;
              state        <= DONE;
            end else if (mis) begin
              out_data     <= '0;
              out_misalign <= 1'b1;
              state        <= DONE;
            end else begin
              out_misalign <= 1'b0;
              req_addr     <= {addr_i[XLEN-1:3], 3'b000};
              req_wen      <= is_store_i;
              req_wdata    <= is_store_i ?
                              (repl << {addr_i[2:0], 3'b000}) :
                              64'd0;
              req_wmask    <= is_store_i ?
                              (mbase << addr_i[2:0]) : 8'd0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (req_ready) state <= WAIT;
        end
        WAIT: begin
          if (resp_valid) begin
            out_data <= ld ? ext : '0;
            state    <= DONE;
          end
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: loads, stores, misalign,
// stalls and reset mid-transaction.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [4:0]  rd_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misalign;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load_i(is_load_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rd_i(rd_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .out_misalign(out_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic issue(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [63:0] a,
                       input logic [63:0] w,
                       input logic [4:0] rd);
    is_load_i  = ld;
    is_store_i = st;
    funct3_i   = f3;
    addr_i     = a;
    wdata_i    = w;
    rd_i       = rd;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    is_load_i  = 1'b0;
    is_store_i = 1'b0;
    addr_i     = 64'hdead_beef_dead_beef;
    wdata_i    = 64'd0;
  endtask

  task automatic bus(input logic [63:0] rd);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_rdata = rd;
    tick();
    resp_valid = 1'b0;
    resp_rdata = 64'd0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    funct3_i = 3'd0; addr_i = 64'd0; wdata_i = 64'd0;
    rd_i = 5'd0; req_ready = 1'b0; resp_valid = 1'b0;
    resp_rdata = 64'd0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wmask", req_wmask, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // non-memory pass-through
    issue(0, 0, 3'b000, 64'h1234, 0, 5);
    chk("nm_out_valid", out_valid, 1);
    chk("nm_out_data", out_data, 64'h1234);
    chk("nm_out_rd", out_rd, 5);
    chk("nm_req_valid", req_valid, 0);
    chk("nm_in_ready", in_ready, 0);
    retire();
    chk("nm_in_ready_after", in_ready, 1);
    chk("nm_out_valid_after", out_valid, 0);

    // LB sign extend
    issue(1, 0, 3'b000, 64'h8000_0003, 0, 7);
    chk("lb_req_valid", req_valid, 1);
    chk("lb_req_addr", req_addr, 64'h8000_0000);
    chk("lb_req_wen", req_wen, 0);
    chk("lb_req_wmask", req_wmask, 0);
    bus(64'h0000_0000_8000_0000);
    chk("lb_out_valid", out_valid, 1);
    chk("lb_out_data", out_data, 64'hffff_ffff_ffff_ff80);
    chk("lb_out_rd", out_rd, 7);
    retire();

    // LBU
    issue(1, 0, 3'b100, 64'h8000_0003, 0, 8);
    bus(64'h0000_0000_8000_0000);
    chk("lbu_out_data", out_data, 64'h80);
    retire();

    // LH at offset 2, LHU at offset 6, LD
    issue(1, 0, 3'b001, 64'h2002, 0, 1);
    bus(64'h1111_2222_9abc_4444);
    chk("lh_out_data", out_data, 64'hffff_ffff_ffff_9abc);
    retire();
    issue(1, 0, 3'b101, 64'h2006, 0, 1);
    bus(64'hf00d_2222_9abc_4444);
    chk("lhu_out_data", out_data, 64'hf00d);
    retire();
    issue(1, 0, 3'b011, 64'h2008, 0, 1);
    chk("ld_req_addr", req_addr, 64'h2008);
    bus(64'h0123_4567_89ab_cdef);
    chk("ld_out_data", out_data, 64'h0123_4567_89ab_cdef);
    retire();

    // SH at offset 6
    issue(0, 1, 3'b001, 64'h1006, 64'hbeef, 2);
    chk("sh_req_wen", req_wen, 1);
    chk("sh_req_wmask", req_wmask, 8'hc0);
    chk("sh_req_addr", req_addr, 64'h1000);
    chk("sh_req_wdata_hi", req_wdata[63:48], 16'hbeef);
    bus(64'hffff_ffff_ffff_ffff);
    chk("sh_out_data", out_data, 0);
    retire();

    // SB offset 5, SW offset 4, SD
    issue(0, 1, 3'b000, 64'h1005, 64'h12a5, 2);
    chk("sb_req_wmask", req_wmask, 8'h20);
    chk("sb_req_wdata", req_wdata[47:40], 8'ha5);
    bus(0);
    retire();
    issue(0, 1, 3'b010, 64'h1004, 64'hcafe_f00d, 2);
    chk("sw_req_wmask", req_wmask, 8'hf0);
    chk("sw_req_wdata", req_wdata[63:32], 32'hcafe_f00d);
    bus(0);
    retire();
    issue(0, 1, 3'b011, 64'h1008, 64'h1122_3344_5566_7788, 2);
    chk("sd_req_wmask", req_wmask, 8'hff);
    chk("sd_req_wdata", req_wdata, 64'h1122_3344_5566_7788);
    bus(0);
    retire();

    // misaligned LW and SD
    issue(1, 0, 3'b010, 64'h1002, 0, 4);
    chk("lwmis_misalign", out_misalign, 1);
    chk("lwmis_out_valid", out_valid, 1);
    chk("lwmis_req_valid", req_valid, 0);
    chk("lwmis_out_data", out_data, 0);
    retire();
    chk("lwmis_req_after", req_valid, 0);
    issue(0, 1, 3'b011, 64'h1004, 64'h5, 4);
    chk("sdmis_misalign", out_misalign, 1);
    chk("sdmis_req_valid", req_valid, 0);
    retire();

    // stalls on every handshake
    issue(1, 0, 3'b010, 64'h3004, 0, 9);
    chk("st_misalign_clr", out_misalign, 0);
    for (int i = 0; i < 3; i++) begin
      chk("st_req_valid", req_valid, 1);
      chk("st_req_addr", req_addr, 64'h3000);
      chk("st_req_wmask", req_wmask, 0);
      chk("st_in_ready", in_ready, 0);
      tick();
    end
    // response coincident with request handshake is ignored
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    resp_rdata = 64'h5555_5555_5555_5555;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    chk("st_req_done", req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      chk("st_wait_out_valid", out_valid, 0);
      tick();
    end
    resp_valid = 1'b1;
    resp_rdata = 64'h8765_4321_0000_0000;
    tick();
    resp_valid = 1'b0;
    resp_rdata = 64'd0;
    for (int i = 0; i < 2; i++) begin
      chk("st_out_valid", out_valid, 1);
      chk("st_out_data", out_data, 64'hffff_ffff_8765_4321);
      chk("st_out_rd", out_rd, 9);
      chk("st_in_ready", in_ready, 0);
      tick();
    end
    retire();
    chk("st_in_ready_after", in_ready, 1);

    // reset during WAIT
    issue(1, 0, 3'b011, 64'h4000, 0, 3);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_req_valid", req_valid, 0);
    tick();
    rst = 1'b0;
    resp_valid = 1'b1;
    resp_rdata = 64'h7777;
    tick();
    resp_valid = 1'b0;
    chk("rw_late_out_valid", out_valid, 0);
    chk("rw_late_in_ready", in_ready, 1);
    issue(0, 0, 3'b000, 64'h55, 0, 11);
    chk("rw_next_valid", out_valid, 1);
    chk("rw_next_data", out_data, 64'h55);
    chk("rw_next_rd", out_rd, 11);
    retire();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the execute stage in the ysyx_23060251 RV64 core. It takes the execute result as the effective address, or as a pass-through value for non-memory ops. It runs one memory transaction per instruction over a valid/ready data bus and hands the aligned, extended result to writeback through a valid/ready output. It is single-issue, with one instruction in flight.

## Interface
- XLEN, 64, datapath and address width (bus beat is 8 bytes)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  lsu can accept (high only in IDLE)
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store (never both with is_load_i)
- funct3_i  in  3  RISC-V width/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- addr_i  in  XLEN  execute result: effective address or ALU value
- wdata_i  in  XLEN  store data (rs2)
- rd_i  in  5  destination tag, passed through
- req_valid  out  1  bus request
- req_ready  in  1  bus accepts request
- req_wen  out  1  1 = write
- req_addr  out  XLEN  addr with bits [2:0] cleared
- req_wdata  out  64  lane-shifted store data
- req_wmask  out  8  byte enables (0 for reads)
- resp_valid  in  1  read data / write ack
- resp_rdata  in  64  read beat
- out_valid  out  1  result for writeback
- out_ready  in  1  writeback accepts
- out_data  out  XLEN  load result or pass-through value
- out_rd  out  5  latched rd_i
- out_misalign  out  1  access misaligned, no bus access made

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch all inputs.
  - Non-memory op (neither is_load_i nor is_store_i) -> DONE with out_data=addr_i.
  - Misaligned access -> DONE with out_misalign=1 and out_data=0.
  - Otherwise -> REQ.
- Misalignment, with off=addr_i[2:0]:
  - H: off[0]!=0.
  - W: off[1:0]!=0.
  - D: off!=0.
  - B: never misaligned.
  - Stores use funct3[1:0] only.
- REQ: req_valid=1 with req_* held stable until req_ready, then -> WAIT.
- WAIT: on resp_valid -> DONE.
  - Loads: out_data = extend(resp_rdata >> 8*off), sign-extended for B/H/W and zero-extended for BU/HU/WU. D passes through.
  - Stores: out_data=0.
- resp_valid is ignored in every state other than WAIT.
- DONE: out_valid=1 until out_ready, then -> IDLE. Outputs are held stable while stalled.
- Store lanes:
  - req_wdata = wdata_i replicated to width, shifted left by 8*off.
  - req_wmask: B = 0x01<<off, H = 0x03<<off, W = 0x0F<<off, D = 0xFF.
- Loads: req_wen=0 and req_wmask=0.

## Timing
- Reset (async, any state) -> IDLE. Reset values:
  - in_ready=1
  - req_valid=0, req_wen=0, req_addr=0, req_wdata=0, req_wmask=0
  - out_valid=0, out_data=0, out_rd=0, out_misalign=0
- Reset during REQ/WAIT abandons the transaction. A late resp_valid is ignored.
- Accept cycle T. Non-memory and misaligned ops: out_valid from T+1.
- Memory op:
  - req_valid from T+1.
  - If req_ready at T+1, WAIT at T+2. Earliest resp_valid is T+2.
  - out_valid from T+3.
- A response in the same cycle as the request handshake is not supported and is ignored.
- No new accept until the DONE handshake completes. in_ready rises the cycle after out_valid&out_ready.
- All outputs are registered or decoded from state. No combinational path from in_* or resp_* to outputs.

## Test plan
- Non-memory op: addr_i=0x1234, rd_i=5 -> out_valid at T+1, out_data=0x1234, out_rd=5, no req_valid.
- LB at 0x8000_0003, resp_rdata=0x0000_0000_8000_0000 -> req_addr=0x8000_0000, out_data=0xFFFF_FFFF_FFFF_FF80. The same access as LBU gives 0x80.
- SH at 0x1006, wdata_i=0xBEEF -> req_wen=1, req_wmask=0xC0, req_wdata[63:48]=0xBEEF, out_data=0.
- LW at 0x1002 -> out_misalign=1 at T+1, req_valid never asserted.
- Stalls: req_ready low 3 cycles, resp 2 cycles later, out_ready low 2 cycles:
  - req_* stable throughout.
  - out_valid held with data stable.
  - in_ready=0 until handshake.
- Assert rst in WAIT, then drive resp_valid next cycle -> IDLE, out_valid stays 0, the next instruction is accepted normally.
